// File: rtl/mul_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mul_pkg
// Description : Shared types and sizing helpers for the Wallace multiplier
//               and its dot-product accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
package mul_pkg;

  // Accumulator control states: summing a frame, or holding a finished result
  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  // Default multiplier operand width
  localparam int LEN = 8;

  // Width of an unsigned product of two len-bit operands, plus one guard bit
  // so it matches the multiplier's output bus
  function automatic int prod_width(input int len);
    return 2 * len + 1;
  endfunction

  // Counter width able to hold the values 0..max_terms inclusive
  function automatic int cnt_width(input int max_terms);
    return $clog2(max_terms + 1);
  endfunction

endpackage : mul_pkg
`default_nettype wire

// File: rtl/dot_product_accumulator_if.sv
`default_nettype none
// ============================================================================
// Module      : dot_product_accumulator_if
// Description : Product input stream and frame result stream, both
//               valid/ready handshakes.
// Revision    : 1.0 - initial release
// ============================================================================
interface dot_product_accumulator_if #(
  parameter int PROD_W = 17,
  parameter int ACC_W  = 24,
  parameter int CNT_W  = 5
);

  // Product stream (upstream multiplier -> accumulator)
  logic              prod_valid;
  logic              prod_ready;
  logic [PROD_W-1:0] prod_data;
  logic              prod_last;

  // Result stream (accumulator -> downstream consumer)
  logic              res_valid;
  logic              res_ready;
  logic [ACC_W-1:0]  res_data;
  logic [CNT_W-1:0]  res_count;
  logic              res_ovf;

  // Environment side: produces products, consumes results
  modport master (
    output prod_valid,
    input  prod_ready,
    output prod_data,
    output prod_last,
    input  res_valid,
    output res_ready,
    input  res_data,
    input  res_count,
    input  res_ovf
  );

  // Accumulator side: consumes products, produces results
  modport slave (
    input  prod_valid,
    output prod_ready,
    input  prod_data,
    input  prod_last,
    output res_valid,
    input  res_ready,
    output res_data,
    output res_count,
    output res_ovf
  );

endinterface : dot_product_accumulator_if
`default_nettype wire

// File: rtl/dot_product_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : dot_product_accumulator
// Description : Sums a frame of unsigned products into a wide accumulator and
//               emits sum, term count and sticky overflow. A frame closes on
//               prod_last or when MAX_TERMS products have been accepted.
// Revision    : 1.0 - initial release
// ============================================================================
module dot_product_accumulator
  import mul_pkg::*;
#(
  parameter int LEN       = mul_pkg::LEN,
  parameter int PROD_W    = prod_width(LEN),
  parameter int ACC_W     = 24,
  parameter int MAX_TERMS = 16,
  parameter int CNT_W     = cnt_width(MAX_TERMS)
) (
  input  wire logic                      clk,
  input  wire logic                      rst,
  input  wire logic                      clr,
  dot_product_accumulator_if.slave       bus
);

  // Frame-close threshold in counter width; MAX_TERMS always fits in CNT_W
  localparam logic [CNT_W-1:0] MAX_TERMS_C = CNT_W'(MAX_TERMS);

  // Architectural state
  state_t             state;
  logic [ACC_W-1:0]   acc;
  logic [CNT_W-1:0]   cnt;
  logic               ovf;

  // Registered result outputs
  logic               out_valid;
  logic [ACC_W-1:0]   out_data;
  logic [CNT_W-1:0]   out_count;
  logic               out_ovf;

  // Datapath
  logic [ACC_W:0]     sum_ext;
  logic [ACC_W-1:0]   sum;
  logic               carry;
  logic [CNT_W-1:0]   cnt_next;
  logic               ovf_next;
  logic               ready;
  logic               accept;
  logic               close;

  // Ready depends only on state and the clear/reset controls, never on valid
  assign ready = (state == ACCUM) && !clr && !rst;
  assign accept = bus.prod_valid && ready;

  // One extra bit on the adder captures the carry out of the accumulator
  assign sum_ext  = (ACC_W+1)'(acc) + (ACC_W+1)'(bus.prod_data);
  assign sum      = sum_ext[ACC_W-1:0];
  assign carry    = sum_ext[ACC_W];
  assign ovf_next = ovf | carry;

  // cnt never exceeds MAX_TERMS-1 while accumulating, so +1 cannot wrap
  assign cnt_next = cnt + CNT_W'(1);

  // A last flag on the MAX_TERMS-th product still yields a single close
  assign close = accept && (bus.prod_last || (cnt_next == MAX_TERMS_C));

  // Control FSM with accumulator, counter, overflow and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ACCUM;
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_count <= '0;
      out_ovf   <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (clr) begin
            // Soft clear drops the partial frame; result outputs untouched
            acc <= '0;
            cnt <= '0;
            ovf <= 1'b0;
          end else if (accept) begin
            acc <= sum;
            cnt <= cnt_next;
            ovf <= ovf_next;
            if (close) begin
              out_valid <= 1'b1;
              out_data  <= sum;
              out_count <= cnt_next;
              out_ovf   <= ovf_next;
              state     <= HOLD;
            end
          end
        end
        HOLD: begin
          // clr is ignored here so a finished result is never discarded
          if (out_valid && bus.res_ready) begin
            out_valid <= 1'b0;
            acc       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            state     <= ACCUM;
          end
        end
        default: begin
          state <= ACCUM;
        end
      endcase
    end
  end

  // Drive the result stream purely from registers
  assign bus.prod_ready = ready;
  assign bus.res_valid  = out_valid;
  assign bus.res_data   = out_data;
  assign bus.res_count  = out_count;
  assign bus.res_ovf    = out_ovf;

endmodule : dot_product_accumulator
`default_nettype wire
